// File: rtl/muldiv_hilo_ctrl.sv
// Execute-stage MIPS multiply/divide controller: owns HI/LO, drives the multiplier and
// sequences the divider handshake. Optional DIV_ZERO_FAST_EN: divide-by-zero bypasses the divider.
module muldiv_hilo_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_valid,
  input  logic [5:0]  es_op,
  input  logic [31:0] es_src1,
  input  logic [31:0] es_src2,
  input  logic        es_flush,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  mul_op,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  input  logic [63:0] mul_result,
  output logic [1:0]  div_op,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_req_valid,
  input  logic        div_req_ready,
  input  logic        div_resp_valid,
  output logic        div_resp_ready,
  input  logic [63:0] div_result
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StReq   = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] dividend_q, divisor_q;
  logic [1:0]  div_op_q;
  logic        req_pend_q, req_pend_d;

  logic is_mul, is_div, is_mthi, is_mtlo, st_idle, go, div_zero, div_start;

  assign is_mul  = es_op[0] | es_op[1];
  assign is_div  = es_op[2] | es_op[3];
  assign is_mthi = es_op[4];
  assign is_mtlo = es_op[5];
  assign st_idle = (state_q == StIdle);
  assign go      = es_valid & ~es_flush & st_idle;

`ifdef DIV_ZERO_FAST_EN
  assign div_zero = is_div & (es_src2 == 32'd0);
`else
  assign div_zero = 1'b0;
`endif

  assign div_start = go & is_div & ~div_zero;

  assign mul_op   = es_valid ? {es_op[1], es_op[0]} : 2'b00;
  assign mul_src1 = es_src1;
  assign mul_src2 = es_src2;

  // In IDLE the request is driven straight from execute; afterwards from the latched copy.
  assign div_op       = st_idle ? (div_start ? {es_op[3], es_op[2]} : 2'b00) : div_op_q;
  assign div_dividend = st_idle ? es_src1 : dividend_q;
  assign div_divisor  = st_idle ? es_src2 : divisor_q;

  // A flushed request stays up in DRAIN until the divider takes it.
  assign div_req_valid  = div_start | (state_q == StReq) | ((state_q == StDrain) & req_pend_q);
  assign div_resp_ready = (state_q == StWait) | (state_q == StDrain);

  assign md_stall = div_start | (state_q == StReq) | ((state_q == StWait) & ~div_resp_valid) |
                    ((state_q == StDrain) & es_valid & (es_op != 6'd0));

  assign hi = hi_q;
  assign lo = lo_q;

  always_comb begin
    state_d    = state_q;
    req_pend_d = req_pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      StIdle: begin
        req_pend_d = 1'b0;
        if (go) begin
          if (is_mul) begin
            {hi_d, lo_d} = mul_result;
          end else if (is_mthi) begin
            hi_d = es_src1;
          end else if (is_mtlo) begin
            lo_d = es_src1;
          end else if (div_zero) begin
            hi_d = es_src1;
            lo_d = 32'hFFFF_FFFF;
          end else if (is_div) begin
            state_d = div_req_ready ? StWait : StReq;
          end
        end
      end
      StReq: begin
        if (es_flush) begin
          state_d    = StDrain;
          req_pend_d = ~div_req_ready;
        end else if (div_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (div_resp_valid) begin
          if (!es_flush) begin
            {hi_d, lo_d} = div_result;
          end
          state_d = StIdle;
        end else if (es_flush) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (req_pend_q) begin
          if (div_req_ready) begin
            req_pend_d = 1'b0;
          end
        end else if (div_resp_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      req_pend_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      dividend_q <= 32'd0;
      divisor_q  <= 32'd0;
      div_op_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      req_pend_q <= req_pend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      if (div_start) begin
        dividend_q <= es_src1;
        divisor_q  <= es_src2;
        div_op_q   <= {es_op[3], es_op[2]};
      end
    end
  end

  op_onehot_a: assert property (@(posedge clk) disable iff (!resetn) es_valid |-> $onehot0(es_op));

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl with a transaction-level HI/LO model, a stub
// multiplier and a latency-programmable stub divider.
module tb_muldiv_hilo_ctrl;

  localparam logic [5:0] OpMult  = 6'b000001;
  localparam logic [5:0] OpMultu = 6'b000010;
  localparam logic [5:0] OpDiv   = 6'b000100;
  localparam logic [5:0] OpDivu  = 6'b001000;
  localparam logic [5:0] OpMthi  = 6'b010000;
  localparam logic [5:0] OpMtlo  = 6'b100000;
`ifdef DIV_ZERO_FAST_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  logic        clk, resetn, es_valid, es_flush, md_stall;
  logic [5:0]  es_op;
  logic [31:0] es_src1, es_src2, hi, lo, mul_src1, mul_src2, div_dividend, div_divisor;
  logic [1:0]  mul_op, div_op;
  logic [63:0] mul_result, div_result;
  logic        div_req_valid, div_req_ready, div_resp_valid, div_resp_ready;

  muldiv_hilo_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .es_valid       (es_valid),
    .es_op          (es_op),
    .es_src1        (es_src1),
    .es_src2        (es_src2),
    .es_flush       (es_flush),
    .md_stall       (md_stall),
    .hi             (hi),
    .lo             (lo),
    .mul_op         (mul_op),
    .mul_src1       (mul_src1),
    .mul_src2       (mul_src2),
    .mul_result     (mul_result),
    .div_op         (div_op),
    .div_dividend   (div_dividend),
    .div_divisor    (div_divisor),
    .div_req_valid  (div_req_valid),
    .div_req_ready  (div_req_ready),
    .div_resp_valid (div_resp_valid),
    .div_resp_ready (div_resp_ready),
    .div_result     (div_result)
  );

  always begin
    clk = 1'b0;
    #5;
    clk = 1'b1;
    #5;
  end

  function automatic logic [63:0] ref_mul(input logic uns, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = uns ? {32'd0, a} : {{32{a[31]}}, a};
    eb = uns ? {32'd0, b} : {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  // {remainder, quotient}; divide-by-zero returns {dividend, all ones}.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Stub multiplier driven only by what the DUT presents.
  always_comb mul_result = ref_mul(mul_op[1], mul_src1, mul_src2);

  // Stub divider: ready after ready_delay request cycles, response lat cycles after accept.
  int          lat, ready_delay, stub_cnt, wait_cnt;
  logic        stub_busy, inject;
  logic [63:0] stub_res;

  assign div_req_ready  = !stub_busy && (wait_cnt >= ready_delay);
  assign div_resp_valid = (stub_busy && stub_cnt == 0) || inject;
  assign div_result     = inject ? 64'hDEAD_BEEF_0BAD_F00D : stub_res;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
      wait_cnt  <= 0;
      stub_res  <= 64'd0;
    end else if (div_req_valid && div_req_ready) begin
      stub_busy <= 1'b1;
      stub_cnt  <= lat - 1;
      wait_cnt  <= 0;
      stub_res  <= ref_div(div_op[0], div_dividend, div_divisor);
    end else begin
      if (div_req_valid) wait_cnt <= wait_cnt + 1;
      if (stub_busy && stub_cnt > 0) stub_cnt <= stub_cnt - 1;
      if (stub_busy && stub_cnt == 0 && div_resp_ready) stub_busy <= 1'b0;
    end
  end

  // Transaction model: one outstanding divide, possibly cancelled by a flush.
  logic [31:0] m_hi, m_lo, m_dvd, m_dvs;
  logic [1:0]  m_op;
  logic        m_out, m_cancel, m_acc;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_dvd <= 32'd0; m_dvs <= 32'd0; m_op <= 2'b00;
      m_out <= 1'b0; m_cancel <= 1'b0; m_acc <= 1'b0;
    end else if (m_out) begin
      if (!m_acc && div_req_ready) m_acc <= 1'b1;
      if (es_flush) m_cancel <= 1'b1;
      if (m_acc && div_resp_valid) begin
        m_out <= 1'b0;
        if (!m_cancel && !es_flush) {m_hi, m_lo} <= div_result;
      end
    end else if (es_valid && !es_flush) begin
      if (es_op == OpMult || es_op == OpMultu) begin
        {m_hi, m_lo} <= ref_mul(es_op == OpMultu, es_src1, es_src2);
      end else if (es_op == OpMthi) begin
        m_hi <= es_src1;
      end else if (es_op == OpMtlo) begin
        m_lo <= es_src1;
      end else if (es_op == OpDiv || es_op == OpDivu) begin
        if (Fast && es_src2 == 32'd0) begin
          m_hi <= es_src1;
          m_lo <= 32'hFFFF_FFFF;
        end else begin
          m_out <= 1'b1; m_cancel <= 1'b0; m_acc <= div_req_ready;
          m_dvd <= es_src1; m_dvs <= es_src2; m_op <= {es_op == OpDivu, es_op == OpDiv};
        end
      end
    end
  end

  int   checks, failures;
  logic cmp_en;
  logic acc_div, exp_stall, exp_req, exp_rr;
  logic [31:0] exp_dvd, exp_dvs;
  logic [1:0]  exp_op;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Presents one instruction and holds it until the stage is no longer stalled.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int stalls, output int reqs);
    int n;
    stalls = 0;
    reqs   = 0;
    es_valid = 1'b1; es_op = op; es_src1 = a; es_src2 = b;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (div_req_valid) reqs++;
      if (!md_stall) break;
      stalls++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL issue_timeout: stalled %0d cycles, limit 200", n);
    end
    @(posedge clk);
    #1;
    es_valid = 1'b0; es_op = 6'd0;
  endtask

  int sc, rc;

  initial begin
    checks = 0; failures = 0; cmp_en = 1'b0;
    resetn = 1'b0; es_valid = 1'b0; es_op = 6'd0; es_src1 = 32'd0; es_src2 = 32'd0;
    es_flush = 1'b0; lat = 10; ready_delay = 0; inject = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (resetn && cmp_en) begin
          acc_div   = es_valid && !es_flush && !m_out && (es_op == OpDiv || es_op == OpDivu) &&
                      !(Fast && es_src2 == 32'd0);
          exp_stall = acc_div || (m_out && !m_cancel && !(m_acc && div_resp_valid)) ||
                      (m_out && m_cancel && es_valid && es_op != 6'd0);
          exp_req   = acc_div || (m_out && !m_acc);
          exp_rr    = m_out && (m_acc || m_cancel);
          exp_dvd   = acc_div ? es_src1 : m_dvd;
          exp_dvs   = acc_div ? es_src2 : m_dvs;
          exp_op    = acc_div ? {es_op == OpDivu, es_op == OpDiv} : m_op;
          chk32("hi", hi, m_hi);
          chk32("lo", lo, m_lo);
          chk1("md_stall", md_stall, exp_stall);
          chk1("div_req_valid", div_req_valid, exp_req);
          chk1("div_resp_ready", div_resp_ready, exp_rr);
          if (exp_req) begin
            chk32("div_dividend", div_dividend, exp_dvd);
            chk32("div_divisor", div_divisor, exp_dvs);
            chk32("div_op", {30'd0, div_op}, {30'd0, exp_op});
          end
          if (es_valid) chk32("mul_op", {30'd0, mul_op}, {30'd0, es_op[1:0]});
        end
      end
    join_none

    #1;
    chk32("rst_hi", hi, 32'd0);
    chk32("rst_lo", lo, 32'd0);
    chk1("rst_md_stall", md_stall, 1'b0);
    chk1("rst_req_valid", div_req_valid, 1'b0);
    chk1("rst_resp_ready", div_resp_ready, 1'b0);
    chk32("rst_mul_op", {30'd0, mul_op}, 32'd0);
    chk32("rst_div_op", {30'd0, div_op}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk);
    #1;

    // Signed then unsigned multiply of the same operands.
    issue(OpMult, 32'hFFFF_FFFE, 32'd3, sc, rc);
    chk32("mult_hi", hi, 32'hFFFF_FFFF);
    chk32("mult_lo", lo, 32'hFFFF_FFFA);
    chk32("mult_stalls", sc, 0);
    issue(OpMultu, 32'hFFFF_FFFE, 32'd3, sc, rc);
    chk32("multu_hi", hi, 32'h0000_0002);
    chk32("multu_lo", lo, 32'hFFFF_FFFA);
    chk32("multu_stalls", sc, 0);

    // -7 / 2, divider latency 10, request accepted at once.
    lat = 10;
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2, sc, rc);
    chk32("div_stalls", sc, 10);
    chk32("div_lo", lo, 32'hFFFF_FFFD);
    chk32("div_hi", hi, 32'hFFFF_FFFF);

    // 100 / 7 unsigned with the request held off for 3 cycles.
    ready_delay = 3;
    lat = 4;
    issue(OpDivu, 32'd100, 32'd7, sc, rc);
    chk32("divu_req_cycles", rc, 4);
    chk32("divu_lo", lo, 32'd14);
    chk32("divu_hi", hi, 32'd2);
    ready_delay = 0;

    // Flush while waiting: response discarded, a following MULT waits for the drain.
    lat = 6;
    es_valid = 1'b1; es_op = OpDiv; es_src1 = 32'd50; es_src2 = 32'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    es_flush = 1'b1;
    @(posedge clk); #1;
    es_flush = 1'b0; es_valid = 1'b0; es_op = 6'd0;
    @(negedge clk);
    chk1("drain_stall", md_stall, 1'b0);
    chk32("drain_hi", hi, 32'd2);
    chk32("drain_lo", lo, 32'd14);
    @(posedge clk); #1;
    issue(OpMult, 32'd6, 32'd7, sc, rc);
    chk32("drain_mult_stalls", sc, 3);
    chk32("drain_mult_hi", hi, 32'd0);
    chk32("drain_mult_lo", lo, 32'd42);

    // Back-to-back moves into HI and LO.
    issue(OpMthi, 32'h0000_1234, 32'd0, sc, rc);
    issue(OpMtlo, 32'h0000_5678, 32'd0, sc, rc);
    chk32("mthi_hi", hi, 32'h0000_1234);
    chk32("mtlo_lo", lo, 32'h0000_5678);

    // Reset in the middle of a divide, then a stale response must be ignored.
    lat = 10;
    es_valid = 1'b1; es_op = OpDiv; es_src1 = 32'd50; es_src2 = 32'd5;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    resetn = 1'b0; es_valid = 1'b0; es_op = 6'd0;
    #1;
    chk32("midrst_hi", hi, 32'd0);
    chk32("midrst_lo", lo, 32'd0);
    chk1("midrst_stall", md_stall, 1'b0);
    chk1("midrst_resp_ready", div_resp_ready, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;
    inject = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    inject = 1'b0;
    chk32("stale_hi", hi, 32'd0);
    chk32("stale_lo", lo, 32'd0);

    // Divide by zero: fast path never requests; otherwise the divider answers.
    lat = 3;
    issue(OpDiv, 32'd9, 32'd0, sc, rc);
    chk32("divz_req_cycles", rc, Fast ? 0 : 1);
    chk32("divz_hi", hi, 32'd9);
    chk32("divz_lo", lo, 32'hFFFF_FFFF);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
